frame_loader: RTL and testbench

FRAME_LOADER -- requirements
Module: frame_loader

---
 rtl/frame_loader.sv | 111 +++++++++++
 tb/tb_frame_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_loader.sv
// Serial pixel loader: assembles a WIDTH-pixel frame, runs the classifier and
// captures its result. Optional RUN watchdog: define FRAME_LOADER_TIMEOUT_EN.
module frame_loader #(
   parameter int WIDTH          = 25,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_in,
   input  logic             pix_valid,
   output logic             pix_ready,
   output logic [WIDTH-1:0] frame_out,
   output logic             en_out,
   input  logic             cls_ready,
   input  logic [1:0]       cls_out,
   output logic [1:0]       result,
   output logic             result_valid,
   input  logic             result_ack
);

   localparam int IDX_W = $clog2(WIDTH + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      RUN    = 2'd1,
      RESULT = 2'd2
   } state_t;

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [WIDTH-1:0] frame_q;
   logic             guard_q;
   logic [1:0]       result_q;
   logic             result_valid_q;

`ifdef FRAME_LOADER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] wd_q;
`endif

   // Valid/ready: a pixel transfers on a rising edge where pix_valid and
   // pix_ready are both 1; pix_ready is high exactly while in LOAD.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= LOAD;
         idx_q          <= '0;
         frame_q        <= '0;
         guard_q        <= 1'b0;
         result_q       <= 2'b00;
         result_valid_q <= 1'b0;
`ifdef FRAME_LOADER_TIMEOUT_EN
         wd_q           <= '0;
`endif
      end else begin
         case (state_q)
            LOAD: begin
               if (pix_valid) begin
                  frame_q[idx_q] <= pix_in;
                  if (idx_q == LAST_IDX) begin
                     idx_q   <= '0;
                     guard_q <= 1'b1;
                     state_q <= RUN;
`ifdef FRAME_LOADER_TIMEOUT_EN
                     wd_q    <= '0;
`endif
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            RUN: begin
               // The first RUN cycle masks cls_ready left over from the last frame.
               guard_q <= 1'b0;
`ifdef FRAME_LOADER_TIMEOUT_EN
               wd_q    <= wd_q + 1'b1;
`endif
               if (!guard_q && cls_ready) begin
                  result_q       <= cls_out;
                  result_valid_q <= 1'b1;
                  state_q        <= RESULT;
               end
`ifdef FRAME_LOADER_TIMEOUT_EN
               else if (wd_q == WD_LAST) begin
                  result_q       <= 2'b11;
                  result_valid_q <= 1'b1;
                  state_q        <= RESULT;
               end
`endif
            end
            RESULT: begin
               if (result_ack) begin
                  result_valid_q <= 1'b0;
                  state_q        <= LOAD;
               end
            end
            default: begin
               state_q <= LOAD;
            end
         endcase
      end
   end

   assign pix_ready    = (state_q == LOAD);
   assign en_out       = (state_q == RUN);
   assign frame_out    = frame_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader: table-driven frames plus hand-written
// sequences for reset, ignored inputs and the RUN watchdog.
module tb_frame_loader;

   localparam int W = 25;

   logic         clk;
   logic         rst;
   logic         pix_in;
   logic         pix_valid;
   logic         pix_ready;
   logic [W-1:0] frame_out;
   logic         en_out;
   logic         cls_ready;
   logic [1:0]   cls_out;
   logic [1:0]   result;
   logic         result_valid;
   logic         result_ack;

   int n_checks = 0;
   int n_pass   = 0;

   frame_loader #(.WIDTH(W), .TIMEOUT_CYCLES(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .pix_in      (pix_in),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .frame_out   (frame_out),
      .en_out      (en_out),
      .cls_ready   (cls_ready),
      .cls_out     (cls_out),
      .result      (result),
      .result_valid(result_valid),
      .result_ack  (result_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] frame;
      bit           toggle;
      int           exp_cycles;
      logic [1:0]   guard_cls;
      logic [1:0]   cls;
      logic [1:0]   exp_result;
      int           ack_wait;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Streams one frame LSB first; returns cycles used and cycles where the
   // bench offered a pixel while pix_ready was low.
   task automatic send_frame(input logic [W-1:0] f, input bit toggle,
                             output int cycles, output int ready_miss);
      int  k = 0;
      bit  v = 1'b1;
      cycles     = 0;
      ready_miss = 0;
      while (k < W && cycles < 200) begin
         pix_valid = v;
         pix_in    = f[k];
         if (v) begin
            if (pix_ready !== 1'b1) ready_miss++;
            k++;
         end
         step();
         cycles++;
         if (toggle) v = ~v;
      end
      pix_valid = 1'b0;
      pix_in    = 1'b0;
   endtask

   // Called in the first RUN cycle: guard-cycle ready, one idle cycle with a
   // stray ack, then the real classifier ready.
   task automatic classify(input logic [1:0] guard_cls, input logic [1:0] cls);
      cls_ready = 1'b1;
      cls_out   = guard_cls;
      step();
      chk("guard_ignored_en", en_out, 1);
      chk("guard_ignored_rv", result_valid, 0);
      cls_ready  = 1'b0;
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      chk("ack_ignored_in_run", en_out, 1);
      cls_ready = 1'b1;
      cls_out   = cls;
      step();
      cls_ready = 1'b0;
      cls_out   = 2'b00;
   endtask

   task automatic ack_result(input int wait_cycles, input logic [1:0] exp_res);
      int bad = 0;
      for (int i = 0; i < wait_cycles; i++) begin
         step();
         if (result !== exp_res || result_valid !== 1'b1 || pix_ready !== 1'b0) bad++;
      end
      chk("result_held_cycles_bad", bad, 0);
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      chk("ack_rv_cleared", result_valid, 0);
      chk("ack_pix_ready", pix_ready, 1);
      chk("ack_result_kept", result, exp_res);
   endtask

   initial begin
      int cyc;
      int miss;

      vecs[0] = '{25'h1101011, 1'b0, 25, 2'b10, 2'b01, 2'b01, 10};
      vecs[1] = '{25'h1101011, 1'b1, 49, 2'b01, 2'b10, 2'b10, 2};
      vecs[2] = '{25'h1ABCDEF, 1'b1, 49, 2'b10, 2'b00, 2'b00, 0};
      vecs[3] = '{25'h0000001, 1'b0, 25, 2'b11, 2'b10, 2'b10, 1};
      vecs[4] = '{25'h1000000, 1'b0, 25, 2'b00, 2'b01, 2'b01, 3};

      rst        = 1'b1;
      pix_in     = 1'b0;
      pix_valid  = 1'b0;
      cls_ready  = 1'b0;
      cls_out    = 2'b00;
      result_ack = 1'b0;
      step();
      step();
      chk("reset_pix_ready", pix_ready, 1);
      chk("reset_en_out", en_out, 0);
      chk("reset_frame", frame_out, 0);
      chk("reset_result", result, 0);
      chk("reset_rv", result_valid, 0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         send_frame(vecs[i].frame, vecs[i].toggle, cyc, miss);
         chk("load_cycles", cyc, vecs[i].exp_cycles);
         chk("load_ready_miss", miss, 0);
         chk("frame_out", frame_out, vecs[i].frame);
         chk("run_en_out", en_out, 1);
         chk("run_pix_ready", pix_ready, 0);
         chk("run_rv", result_valid, 0);
         classify(vecs[i].guard_cls, vecs[i].cls);
         chk("result", result, vecs[i].exp_result);
         chk("result_valid", result_valid, 1);
         chk("result_en_out", en_out, 0);
         chk("result_frame_held", frame_out, vecs[i].frame);
         ack_result(vecs[i].ack_wait, vecs[i].exp_result);
      end

      // A pixel offered in the first RUN cycle must not land in the frame.
      send_frame(25'h0000000, 1'b0, cyc, miss);
      chk("zero_frame", frame_out, 0);
      pix_valid = 1'b1;
      pix_in    = 1'b1;
      step();
      pix_valid = 1'b0;
      pix_in    = 1'b0;
      chk("run_pixel_ignored", frame_out, 0);
`ifdef FRAME_LOADER_TIMEOUT_EN
      for (int i = 0; i < 6; i++) step();
      chk("wd_before_limit_en", en_out, 1);
      chk("wd_before_limit_rv", result_valid, 0);
      step();
      chk("wd_result", result, 2'b11);
      chk("wd_rv", result_valid, 1);
      chk("wd_en_out", en_out, 0);
      ack_result(1, 2'b11);
`else
      for (int i = 0; i < 20; i++) step();
      chk("no_wd_still_run", en_out, 1);
      chk("no_wd_rv", result_valid, 0);
      cls_ready = 1'b1;
      cls_out   = 2'b10;
      step();
      cls_ready = 1'b0;
      chk("late_result", result, 2'b10);
      ack_result(1, 2'b10);
`endif

      // Reset after 12 pixels discards the partial frame.
      for (int i = 0; i < 12; i++) begin
         pix_valid = 1'b1;
         pix_in    = 1'b1;
         step();
      end
      pix_valid = 1'b0;
      rst       = 1'b1;
      step();
      rst = 1'b0;
      chk("midframe_rst_frame", frame_out, 0);
      chk("midframe_rst_result", result, 0);
      chk("midframe_rst_ready", pix_ready, 1);
      send_frame(25'h0A5A5A5, 1'b0, cyc, miss);
      chk("after_rst_cycles", cyc, 25);
      chk("after_rst_frame", frame_out, 25'h0A5A5A5);
      chk("after_rst_rv", result_valid, 0);

      // Reset in the middle of RUN.
      step();
      chk("pre_rst_run", en_out, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("run_rst_en", en_out, 0);
      chk("run_rst_ready", pix_ready, 1);
      chk("run_rst_frame", frame_out, 0);
      chk("run_rst_rv", result_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
